encoder_rpm_sched: RTL and testbench
====================================

Name: encoder_rpm_sched

Overview:
Measurement controller for several quadrature-free encoder channels. It generates the gate window and runs one saturating tick counter per channel. At each window end it snapshots all counts. A single shared multiply/shift unit then converts each snapshot to RPM in sequence, and results leave through a valid/ready stream tagged with the channel index. The block sits between the raw encoder tick pins and the RPM consumer (display/UART).

Parameters:
NUM_CH, 4, number of encoder channels (1..8)
COUNT_W, 12, live/snapshot tick counter width
RPM_W, 15, output RPM width
WIN_W, 29, window length register width
RPM_MULT, 1125000, RPM scale constant (60*18750); fits in 21 bits
RPM_SHIFT, 8, right shift applied after multiply (divide by 256)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
enable  in  1  1 = windows run; 0 = timer and live counters held at 0
window_len  in  WIN_W  gate length in clk cycles; sampled at each window start; values <16 are treated as 16
ticks  in  NUM_CH  asynchronous encoder tick inputs; min 2 clk high and 2 clk low
rpm_data  out  RPM_W  RPM result, saturated
rpm_ch  out  clog2(NUM_CH) (min 1)  channel index of rpm_data
rpm_valid  out  1  result valid; held until accepted
rpm_ready  in  1  consumer accepts when rpm_valid & rpm_ready
busy  out  1  sequencer not IDLE
overrun  out  1  sticky: a window ended while the sequencer was busy; cleared by reset or enable=0

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, FSM=IDLE, timer=0, all counters and snapshots 0, sync flops 0. Reset mid-sequence aborts it, and rpm_valid is 0 after that edge.
- Per channel: 2-flop synchroniser, then a rising-edge detector. A ticks rise is counted on the 3rd clk edge after it. The live count saturates at 2^COUNT_W-1.
- Window timer: counts 0..len-1 while enable=1. Terminal cycle is timer==len-1; on that cycle the timer goes to 0 and len reloads from window_len.
- Terminal cycle, FSM=IDLE: snap[i] <= live[i] (including any edge detected in that cycle). Live counters are cleared to 0. FSM enters MUL with idx=0.
- Terminal cycle, FSM busy: the snapshot is dropped and live counters are still cleared. overrun <= 1. The in-flight sequence continues undisturbed.
- enable=0: timer and live counters are forced to 0 and no new windows start. An in-progress sequence completes normally. overrun is cleared.
- FSM states:
  - IDLE: waits for a terminal cycle.
  - MUL (1 cycle): prod <= snap[idx]*RPM_MULT, width COUNT_W+21, unsigned.
  - OUT: rpm_data = min(prod>>RPM_SHIFT, 2^RPM_W-1); rpm_ch = idx; rpm_valid = 1.
  - OUT on handshake: if idx==NUM_CH-1 then IDLE, else idx+1 and MUL.
- rpm_data and rpm_ch are registered and stable while rpm_valid=1 && !rpm_ready.
- Latency: first rpm_valid asserts 2 clk after the terminal cycle. With rpm_ready held high, each channel takes 2 cycles.
- busy=1 in MUL and OUT.
- Floor division only (truncate); no rounding.

Decomposition:
- Shared package encoder_pkg holds:
  - RPM_MULT and RPM_SHIFT defaults
  - FSM state enum (IDLE, MUL, OUT)
  - saturating-truncate function sat_rpm(prod)
- One natural sub-module, tick_counter: synchroniser + edge detect + saturating counter with clear and snapshot-out. It is instantiated NUM_CH times.

Test Plan:
- Basic conversion. Setup: NUM_CH=2, window_len=100, rpm_ready=1; 5 ticks on ch0 and 3 on ch1 inside one window. Required: ch0 then ch1 emitted with rpm_data 21972 then 13183; first rpm_valid 2 clk after the terminal cycle.
- Saturation. Stimulus: 8 ticks on ch0 in one window. Required: rpm_data=32767 (raw 35156). Separately, 4100 ticks with COUNT_W=12 saturate the count at 4095.
- Boundary tick. Stimulus: edge detected exactly on the terminal cycle. Required: it counts into the closing window's snapshot; a detected edge 1 cycle later is counted in the next window only.
- Backpressure/overrun. Setup: window_len=100, rpm_ready held 0 for 300 cycles. Required: rpm_valid stays 1 with data/ch stable, overrun=1, and the original results drain in order once ready=1. enable 1→0 clears overrun.
- Reset mid-operation. Stimulus: assert rst_n=0 while in OUT. Required: rpm_valid=0, busy=0, all counts 0 on the next edge; the first post-reset window produces counts from new ticks only.
- window_len=3 is clamped to 16. Required: successive terminal cycles are 16 clk apart.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared constants, sequencer states and the RPM saturation helper.
package encoder_pkg;

    localparam int RPM_MULT_DEF  = 1125000;  // 60 * 18750
    localparam int RPM_SHIFT_DEF = 8;        // divide by 256 after multiply
    localparam int MULT_W        = 21;       // RPM_MULT fits in 21 bits

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_OUT
    } state_t;

    // Floor-shift the product and clamp it to the largest rpm_w-bit value.
    function automatic logic [63:0] sat_rpm(input logic [63:0] prod,
                                            input int          shift,
                                            input int          rpm_w);
        logic [63:0] q;
        logic [63:0] lim;
        q   = prod >> shift;
        lim = (64'd1 << rpm_w) - 64'd1;
        return (q > lim) ? lim : q;
    endfunction

endpackage

// File: rtl/encoder_rpm_sched_tick_counter.sv
// One encoder channel: 2-flop synchroniser, rising-edge detect,
// saturating live counter with window clear and snapshot capture.
module tick_counter #(
    parameter int COUNT_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_in,
    input  logic               clr,
    input  logic               snap_en,
    output logic [COUNT_W-1:0] snap_o
);

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               prev_q,  prev_d;
    logic [COUNT_W-1:0] live_q,  live_d;
    logic [COUNT_W-1:0] snap_q,  snap_d;
    logic               rise;
    logic [COUNT_W-1:0] live_inc;

    // Edge detect and counter update; the edge seen on a terminal cycle
    // goes into the snapshot, never into the next window.
    always_comb begin
        sync1_d  = tick_in;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        rise     = sync2_q & ~prev_q;
        live_inc = live_q;
        if (rise && (live_q != CNT_MAX)) begin
            live_inc = live_q + COUNT_W'(1);
        end
        live_d = clr ? '0 : live_inc;
        snap_d = snap_en ? live_inc : snap_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            live_q  <= '0;
            snap_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            live_q  <= live_d;
            snap_q  <= snap_d;
        end
    end

    assign snap_o = snap_q;

endmodule

// File: rtl/encoder_rpm_sched.sv
// Gate-window RPM measurement: per-channel tick counters, window timer,
// and a shared multiply/shift sequencer streaming results by channel.
module encoder_rpm_sched import encoder_pkg::*; #(
    parameter  int NUM_CH    = 4,
    parameter  int COUNT_W   = 12,
    parameter  int RPM_W     = 15,
    parameter  int WIN_W     = 29,
    parameter  int RPM_MULT  = RPM_MULT_DEF,
    parameter  int RPM_SHIFT = RPM_SHIFT_DEF,
    localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [WIN_W-1:0]  window_len,
    input  logic [NUM_CH-1:0] ticks,
    output logic [RPM_W-1:0]  rpm_data,
    output logic [IDX_W-1:0]  rpm_ch,
    output logic              rpm_valid,
    input  logic              rpm_ready,
    output logic              busy,
    output logic              overrun
);

    localparam int                PROD_W   = COUNT_W + MULT_W;
    localparam logic [PROD_W-1:0] MULT_V   = PROD_W'(RPM_MULT);
    localparam logic [WIN_W-1:0]  MIN_LEN  = WIN_W'(16);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);

    logic [WIN_W-1:0]                timer_q, timer_d;
    logic [WIN_W-1:0]                len_q, len_d;
    logic [WIN_W-1:0]                len_in;
    logic                            terminal;
    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [PROD_W-1:0]               prod_q, prod_d;
    logic                            overrun_q, overrun_d;
    logic [NUM_CH-1:0][COUNT_W-1:0]  snap_w;
    logic                            cnt_clr;
    logic                            cnt_snap;

    assign len_in   = (window_len < MIN_LEN) ? MIN_LEN : window_len;
    assign terminal = enable && (timer_q == (len_q - WIN_W'(1)));
    assign cnt_clr  = terminal | ~enable;
    assign cnt_snap = terminal && (state_q == ST_IDLE);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_counter #(.COUNT_W(COUNT_W)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick_in (ticks[i]),
            .clr     (cnt_clr),
            .snap_en (cnt_snap),
            .snap_o  (snap_w[i])
        );
    end

    // Window timer, length reload and sticky overrun flag.
    always_comb begin
        timer_d   = timer_q + WIN_W'(1);
        len_d     = len_q;
        overrun_d = overrun_q;
        if (!enable || terminal) begin
            timer_d = '0;
            len_d   = len_in;
        end
        if (!enable) begin
            overrun_d = 1'b0;
        end else if (terminal && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Sequencer: one multiply per channel, then hold the result until accepted.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        prod_d  = prod_q;
        case (state_q)
            ST_IDLE: begin
                if (terminal) begin
                    state_d = ST_MUL;
                    idx_d   = '0;
                end
            end
            ST_MUL: begin
                prod_d  = PROD_W'(snap_w[idx_q]) * MULT_V;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (rpm_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_MUL;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; length is loaded from window_len while in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q   <= '0;
            len_q     <= len_in;
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            prod_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            len_q     <= len_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            prod_q    <= prod_d;
            overrun_q <= overrun_d;
        end
    end

    assign rpm_data  = RPM_W'(sat_rpm(64'(prod_q), RPM_SHIFT, RPM_W));
    assign rpm_ch    = idx_q;
    assign rpm_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_encoder_rpm_sched.sv
// Self-checking bench: table of tick-count vectors with precomputed RPM,
// scoreboard queue checked on each output handshake, plus corner sequences.
module tb_encoder_rpm_sched;

    localparam int NCH = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [28:0]     window_len;
    logic [NCH-1:0]  ticks;
    logic [14:0]     rpm_data;
    logic [0:0]      rpm_ch;
    logic            rpm_valid;
    logic            rpm_ready;
    logic            busy;
    logic            overrun;

    typedef struct {
        logic [0:0]  ch;
        logic [14:0] data;
    } exp_t;

    typedef struct {
        int n0;
        int n1;
        int e0;
        int e1;
    } vec_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic mon_en = 1'b0;

    encoder_rpm_sched #(.NUM_CH(NCH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .window_len (window_len),
        .ticks      (ticks),
        .rpm_data   (rpm_data),
        .rpm_ch     (rpm_ch),
        .rpm_valid  (rpm_valid),
        .rpm_ready  (rpm_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_rpm(input int cnt);
        longint r;
        r = (longint'(cnt) * 1125000) >>> 8;
        return (r > 32767) ? 32767 : int'(r);
    endfunction

    task automatic push_win(input int e0, input int e1);
        q.push_back('{1'b0, 15'(e0)});
        q.push_back('{1'b1, 15'(e1)});
    endtask

    // Each tick: 2 cycles high, 2 cycles low.
    task automatic drive_ticks(input int n0, input int n1);
        int m;
        m = (n0 > n1) ? n0 : n1;
        for (int k = 0; k < m; k++) begin
            ticks[0] = (k < n0);
            ticks[1] = (k < n1);
            repeat (2) @(negedge clk);
            ticks = '0;
            repeat (2) @(negedge clk);
        end
    endtask

    // Returns at the first negedge where busy has just risen (cycle after a terminal).
    task automatic wait_win(input int lim, output int st);
        logic prev;
        prev = busy;
        st   = -1;
        for (int n = 0; n < lim; n++) begin
            @(negedge clk);
            if (busy && !prev) begin
                st = cyc;
                break;
            end
            prev = busy;
        end
        if (st < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_win: no window end within %0d cycles", lim);
        end
    endtask

    // Scoreboard: compare every accepted result against the head of the queue.
    always @(negedge clk) begin
        #2;
        if (mon_en && rpm_valid && rpm_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: ch %0d data %0d with empty queue", rpm_ch, rpm_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rpm_out{ch,data}", {rpm_ch, rpm_data}, {e.ch, e.data});
            end
        end
    end

    initial begin
        vec_t vecs[5];
        int   st, st_prev;
        logic [14:0] d0;
        logic [0:0]  c0;
        logic        stable;

        vecs[0] = '{5, 3, 21972, 13183};
        vecs[1] = '{8, 0, 32767, 0};
        vecs[2] = '{0, 1, 0, 4394};
        vecs[3] = '{2, 7, 8789, 30761};
        vecs[4] = '{4, 6, 17578, 26367};

        rst_n      = 1'b0;
        enable     = 1'b0;
        window_len = 29'd100;
        ticks      = '0;
        rpm_ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", rpm_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_data", rpm_data, 0);
        chk("rst_ch", rpm_ch, 0);

        rst_n  = 1'b1;
        enable = 1'b1;
        mon_en = 1'b1;

        // First (empty) window; also check first-result latency.
        push_win(0, 0);
        wait_win(200, st);
        chk("latency_t+1_valid", rpm_valid, 0);
        @(negedge clk);
        chk("latency_t+2_valid", rpm_valid, 1);
        st_prev = st;

        foreach (vecs[i]) begin
            push_win(vecs[i].e0, vecs[i].e1);
            drive_ticks(vecs[i].n0, vecs[i].n1);
            wait_win(200, st);
            chk("window_period_100", st - st_prev, 100);
            st_prev = st;
        end

        // Edge on the terminal cycle (ch0) vs one cycle later (ch1).
        push_win(exp_rpm(1), 0);
        repeat (97) @(negedge clk);
        ticks[0] = 1'b1;
        @(negedge clk);
        ticks[1] = 1'b1;
        wait_win(50, st);
        ticks = '0;
        push_win(0, exp_rpm(1));

        // Counter saturation at 4095 with a long window.
        window_len = 29'd20000;
        wait_win(200, st);
        push_win(exp_rpm(4095), 0);
        drive_ticks(4100, 0);
        window_len = 29'd100;
        wait_win(25000, st);
        chk("snap_sat_4095", dut.snap_w[0], 4095);

        // Backpressure: hold ready low across several window ends.
        push_win(exp_rpm(2), exp_rpm(3));
        drive_ticks(2, 3);
        rpm_ready = 1'b0;
        wait_win(200, st);
        @(negedge clk);
        chk("stall_valid", rpm_valid, 1);
        d0 = rpm_data;
        c0 = rpm_ch;
        chk("stall_data", d0, 8789);
        chk("stall_ch", c0, 0);
        stable = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (!rpm_valid || rpm_data != d0 || rpm_ch != c0) stable = 1'b0;
        end
        chk("stall_stable", stable, 1);
        chk("overrun_set", overrun, 1);
        rpm_ready = 1'b1;
        for (int n = 0; n < 50 && busy; n++) @(negedge clk);
        chk("drain_idle", busy, 0);
        enable = 1'b0;
        @(negedge clk);
        chk("overrun_clr_on_disable", overrun, 0);
        chk("queue_empty_after_drain", q.size(), 0);

        // Reset while holding a result in OUT.
        enable = 1'b1;
        drive_ticks(3, 4);
        rpm_ready = 1'b0;
        wait_win(200, st);
        @(negedge clk);
        chk("pre_reset_valid", rpm_valid, 1);
        mon_en = 1'b0;
        q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", rpm_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_snaps", dut.snap_w, 0);
        chk("midrst_live0", dut.g_ch[0].u_cnt.live_q, 0);
        chk("midrst_live1", dut.g_ch[1].u_cnt.live_q, 0);
        rst_n     = 1'b1;
        rpm_ready = 1'b1;
        mon_en    = 1'b1;
        push_win(exp_rpm(1), exp_rpm(2));
        drive_ticks(1, 2);
        wait_win(200, st);

        // Short window lengths are clamped to 16.
        window_len = 29'd3;
        push_win(0, 0);
        wait_win(200, st);
        st_prev = st;
        push_win(0, 0);
        wait_win(200, st);
        chk("clamp_period_16a", st - st_prev, 16);
        st_prev = st;
        push_win(0, 0);
        wait_win(200, st);
        chk("clamp_period_16b", st - st_prev, 16);
        for (int n = 0; n < 20 && busy; n++) @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        chk("queue_empty_end", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
